// File: rtl/bus_interconnect.sv
// Memory-mapped interconnect from the CPU data port to SLAVE_CNT slaves:
// top-bit region decode, req/ack handshake with wait states, timeout and unmapped-address errors.
module bus_interconnect #(
    parameter int SLAVE_CNT   = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REGION_BITS = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                        sysClk,
    input  logic                        sysRes,
    input  logic                        mReq,
    input  logic                        mWe,
    input  logic [DATA_W/8-1:0]         mMask,
    input  logic [ADDR_W-1:0]           mAddr,
    input  logic [DATA_W-1:0]           mWData,
    output logic [DATA_W-1:0]           mRData,
    output logic                        mReady,
    output logic                        mErr,
    output logic [SLAVE_CNT-1:0]        sReq,
    output logic                        sWe,
    output logic [DATA_W/8-1:0]         sMask,
    output logic [ADDR_W-1:0]           sAddr,
    output logic [DATA_W-1:0]           sWData,
    input  logic [SLAVE_CNT*DATA_W-1:0] sRData,
    input  logic [SLAVE_CNT-1:0]        sAck,
    output logic [15:0]                 errCnt
);

    localparam int         MASK_W = DATA_W / 8;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [SLAVE_CNT-1:0]   sreq_q, sreq_d;
    logic                   swe_q, swe_d;
    logic [MASK_W-1:0]      smask_q, smask_d;
    logic [ADDR_W-1:0]      saddr_q, saddr_d;
    logic [DATA_W-1:0]      swdata_q, swdata_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   mready_q, mready_d;
    logic                   merr_q, merr_d;
    logic [DATA_W-1:0]      mrdata_q, mrdata_d;
    logic [15:0]            errcnt_q, errcnt_d;

    logic [REGION_BITS-1:0] region;
    logic [SLAVE_CNT-1:0]   hit;
    logic                   ack_hit;
    logic [DATA_W-1:0]      ack_data;
    logic                   bus_act;

    // One-hot slave hit; an empty vector means the region is unmapped.
    always_comb begin
        region = mAddr[ADDR_W-1 -: REGION_BITS];
        hit    = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            hit[i] = (region == REGION_BITS'(i));
        end
    end

    // sreq_q doubles as the registered slave index, so it masks both ack and read data.
    always_comb begin
        ack_hit  = |(sAck & sreq_q);
        ack_data = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            if (sreq_q[i]) begin
                ack_data = ack_data | sRData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sreq_d   = sreq_q;
        swe_d    = swe_q;
        smask_d  = smask_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        cnt_d    = cnt_q;
        mready_d = 1'b0;
        merr_d   = 1'b0;
        mrdata_d = '0;
        errcnt_d = errcnt_q;

        case (state_q)
            S_IDLE: begin
                if (mReq) begin
                    if (|hit) begin
                        sreq_d   = hit;
                        swe_d    = mWe;
                        smask_d  = mMask;
                        saddr_d  = mAddr;
                        swdata_d = mWData;
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end else begin
                        mready_d = 1'b1;
                        merr_d   = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                // Ack is checked first so an ack on the timeout cycle completes normally.
                if (ack_hit) begin
                    sreq_d   = '0;
                    mready_d = 1'b1;
                    mrdata_d = swe_q ? '0 : ack_data;
                    state_d  = S_RESP;
                end else if (cnt_q == TO_CNT) begin
                    sreq_d   = '0;
                    mready_d = 1'b1;
                    merr_d   = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                sreq_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        if (mready_q && merr_q && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
        end
    end

    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            state_q  <= S_IDLE;
            sreq_q   <= '0;
            swe_q    <= 1'b0;
            smask_q  <= '0;
            saddr_q  <= '0;
            swdata_q <= '0;
            cnt_q    <= '0;
            mready_q <= 1'b0;
            merr_q   <= 1'b0;
            mrdata_q <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sreq_q   <= sreq_d;
            swe_q    <= swe_d;
            smask_q  <= smask_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
            cnt_q    <= cnt_d;
            mready_q <= mready_d;
            merr_q   <= merr_d;
            mrdata_q <= mrdata_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Broadcast slave bus is forced quiet whenever no slave is being requested.
    assign bus_act = |sreq_q;
    assign sReq    = sreq_q;
    assign sWe     = swe_q & bus_act;
    assign sMask   = bus_act ? smask_q  : '0;
    assign sAddr   = bus_act ? saddr_q  : '0;
    assign sWData  = bus_act ? swdata_q : '0;
    assign mReady  = mready_q;
    assign mErr    = merr_q;
    assign mRData  = mrdata_q;
    assign errCnt  = errcnt_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: latency, data, error and reset behaviour
// against hand-computed expectations; slaves ack after a programmable wait.
module tb_bus_interconnect;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            sysClk = 1'b0;
    logic            sysRes = 1'b0;
    logic            mReq   = 1'b0;
    logic            mWe    = 1'b0;
    logic [DW/8-1:0] mMask  = '0;
    logic [AW-1:0]   mAddr  = '0;
    logic [DW-1:0]   mWData = '0;
    logic [DW-1:0]   mRData;
    logic            mReady;
    logic            mErr;
    logic [N-1:0]    sReq;
    logic            sWe;
    logic [DW/8-1:0] sMask;
    logic [AW-1:0]   sAddr;
    logic [DW-1:0]   sWData;
    logic [N*DW-1:0] sRData;
    logic [N-1:0]    sAck;
    logic [15:0]     errCnt;

    int dly  [N];
    int wcnt [N];
    int n_chk = 0;
    int n_err = 0;

    always #5 sysClk = ~sysClk;

    bus_interconnect #(
        .SLAVE_CNT(N), .DATA_W(DW), .ADDR_W(AW), .REGION_BITS(4), .TIMEOUT(15)
    ) dut (
        .sysClk(sysClk), .sysRes(sysRes),
        .mReq(mReq), .mWe(mWe), .mMask(mMask), .mAddr(mAddr), .mWData(mWData),
        .mRData(mRData), .mReady(mReady), .mErr(mErr),
        .sReq(sReq), .sWe(sWe), .sMask(sMask), .sAddr(sAddr), .sWData(sWData),
        .sRData(sRData), .sAck(sAck), .errCnt(errCnt)
    );

    assign sRData = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};

    // Slave i acks combinationally once its request has been held dly[i] cycles.
    always @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            for (int i = 0; i < N; i++) wcnt[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) wcnt[i] <= sReq[i] ? wcnt[i] + 1 : 0;
        end
    end

    always_comb begin
        sAck = '0;
        for (int i = 0; i < N; i++) sAck[i] = sReq[i] && (wcnt[i] >= dly[i]);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is cycle 0. Ends one idle cycle after mReady.
    task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [3:0] mask,
                           input logic [DW-1:0] wdata, output int lat, output logic err,
                           output logic [DW-1:0] rdata, output logic [N-1:0] sreq_or,
                           output int sreq_cyc, output int bad);
        mAddr = addr; mWe = we; mMask = mask; mWData = wdata; mReq = 1'b1;
        lat = -1; err = 1'b0; rdata = '0; sreq_or = '0; sreq_cyc = 0; bad = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge sysClk);
            if (sReq != '0) begin
                sreq_or = sreq_or | sReq;
                sreq_cyc++;
                if (sWe !== we || sAddr !== addr || sWData !== wdata || sMask !== mask) bad++;
            end else if (sWe !== 1'b0 || sAddr !== '0 || sWData !== '0 || sMask !== '0) begin
                bad++;
            end
            if (mReady) begin
                lat = c; err = mErr; rdata = mRData;
                break;
            end
        end
        mReq = 1'b0;
        @(negedge sysClk);
    endtask

    initial begin
        int             lat, scyc, bad, c0, c1;
        logic           err, ovl;
        logic [DW-1:0]  rd, d0, d1;
        logic [N-1:0]   sor;

        for (int i = 0; i < N; i++) dly[i] = 0;

        // Reset state
        @(negedge sysClk);
        chk("rst_sreq",   64'(sReq),   64'h0);
        chk("rst_mready", 64'(mReady), 64'h0);
        chk("rst_merr",   64'(mErr),   64'h0);
        chk("rst_mrdata", 64'(mRData), 64'h0);
        chk("rst_errcnt", 64'(errCnt), 64'h0);
        chk("rst_sbus",   64'({sWe, sMask, sAddr, sWData}), 64'h0);
        sysRes = 1'b1;
        @(negedge sysClk);

        // Zero-wait read, slave 1
        run_txn(32'h1000_0040, 1'b0, 4'hF, 32'h0, lat, err, rd, sor, scyc, bad);
        chk("zw_lat",   64'(lat),  64'd2);
        chk("zw_sreq",  64'(sor),  64'h2);
        chk("zw_scyc",  64'(scyc), 64'd1);
        chk("zw_err",   64'(err),  64'h0);
        chk("zw_rdata", 64'(rd),   64'hDEAD_BEEF);
        chk("zw_bus",   64'(bad),  64'd0);

        // Write with 3 wait states, slave 2
        dly[2] = 3;
        run_txn(32'h2000_0000, 1'b1, 4'b0011, 32'h1234_5678, lat, err, rd, sor, scyc, bad);
        chk("ws_lat",   64'(lat),  64'd5);
        chk("ws_sreq",  64'(sor),  64'h4);
        chk("ws_scyc",  64'(scyc), 64'd4);
        chk("ws_err",   64'(err),  64'h0);
        chk("ws_rdata", 64'(rd),   64'h0);
        chk("ws_bus",   64'(bad),  64'd0);

        // Two timeouts, slave 3 never acks
        dly[3] = 1000;
        run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, lat, err, rd, sor, scyc, bad);
        chk("to1_lat",   64'(lat),  64'd17);
        chk("to1_scyc",  64'(scyc), 64'd16);
        chk("to1_err",   64'(err),  64'h1);
        chk("to1_rdata", 64'(rd),   64'h0);
        chk("to1_cnt",   64'(errCnt), 64'd1);
        run_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, lat, err, rd, sor, scyc, bad);
        chk("to2_lat",   64'(lat),  64'd17);
        chk("to2_err",   64'(err),  64'h1);
        chk("to2_cnt",   64'(errCnt), 64'd2);

        // Unmapped region 8
        run_txn(32'h8000_0000, 1'b1, 4'hF, 32'hFFFF_0000, lat, err, rd, sor, scyc, bad);
        chk("um_lat",   64'(lat),  64'd1);
        chk("um_sreq",  64'(sor),  64'h0);
        chk("um_err",   64'(err),  64'h1);
        chk("um_rdata", 64'(rd),   64'h0);
        chk("um_bus",   64'(bad),  64'd0);
        chk("um_cnt",   64'(errCnt), 64'd3);

        // Ack lands on the timeout cycle: normal completion
        dly[3] = 15;
        run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, lat, err, rd, sor, scyc, bad);
        chk("ato_lat",   64'(lat),  64'd17);
        chk("ato_scyc",  64'(scyc), 64'd16);
        chk("ato_err",   64'(err),  64'h0);
        chk("ato_rdata", 64'(rd),   64'h3333_3333);
        chk("ato_cnt",   64'(errCnt), 64'd3);

        // Reset in the middle of WAIT
        dly[0] = 1000;
        mAddr = 32'h0000_0000; mWe = 1'b0; mMask = 4'hF; mReq = 1'b1;
        @(negedge sysClk);
        @(negedge sysClk);
        chk("mr_sreq_pre", 64'(sReq), 64'h1);
        sysRes = 1'b0; mReq = 1'b0;
        #1;
        chk("mr_sreq_async",   64'(sReq),   64'h0);
        chk("mr_mready_async", 64'(mReady), 64'h0);
        chk("mr_cnt_async",    64'(errCnt), 64'h0);
        @(negedge sysClk);
        sysRes = 1'b1; dly[0] = 0;
        @(negedge sysClk);
        chk("mr_idle_mready", 64'(mReady), 64'h0);
        run_txn(32'h0000_0000, 1'b0, 4'hF, 32'h0, lat, err, rd, sor, scyc, bad);
        chk("mr_lat",   64'(lat), 64'd2);
        chk("mr_err",   64'(err), 64'h0);
        chk("mr_rdata", 64'(rd),  64'hA0A0_0000);
        chk("mr_cnt",   64'(errCnt), 64'd0);

        // Back-to-back reads to slaves 0 then 1 with mReq held high
        dly[0] = 0; dly[1] = 0;
        mAddr = 32'h0000_0004; mWe = 1'b0; mReq = 1'b1;
        c0 = -1; c1 = -1; d0 = '0; d1 = '0; ovl = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge sysClk);
            if ($countones(sReq) > 1) ovl = 1'b1;
            if (mReady) begin
                if (c0 < 0) begin
                    c0 = c; d0 = mRData;
                    mAddr = 32'h1000_0004;
                end else begin
                    c1 = c; d1 = mRData;
                    break;
                end
            end
        end
        mReq = 1'b0;
        @(negedge sysClk);
        chk("b2b_first",  64'(c0), 64'd2);
        chk("b2b_gap",    64'(c1 - c0), 64'd3);
        chk("b2b_data0",  64'(d0), 64'hA0A0_0000);
        chk("b2b_data1",  64'(d1), 64'hDEAD_BEEF);
        chk("b2b_ovl",    64'(ovl), 64'h0);
        chk("b2b_idle",   64'({mReady, sReq}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
